axis_sample_assembler: RTL and testbench
========================================

AXIS_SAMPLE_ASSEMBLER -- requirements
Module: axis_sample_assembler

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024: max idle clocks between bytes inside a frame before abort.
REQ-002 Parameter DATA_WIDTH, default 16: width of each assembled axis sample.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 i_rstn  input  1  reset, synchronous, active-low.
REQ-005 i_frame_start  input  1  one-cycle pulse; a new 6-byte burst (DATAX0..DATAZ1 from SPI master) begins.
REQ-006 i_byte_valid  input  1  one-cycle strobe; i_byte holds a received byte.
REQ-007 i_byte  input  8  received data byte.
REQ-008 i_err_clr  input  1  clears o_err_timeout and o_drop_cnt.
REQ-009 o_x, o_y, o_z  output  DATA_WIDTH each  held axis samples (two's complement), stable between frames, feed averaging stage data_in.
REQ-010 o_valid  output  1  one-cycle pulse; new o_x/o_y/o_z this cycle.
REQ-011 o_busy  output  1  high while a frame is being collected.
REQ-012 o_err_timeout  output  1  sticky; set on any inter-byte timeout abort.
REQ-013 o_drop_cnt  output  8  saturating count of aborted frames (timeout or restart).

Function
REQ-014 FSM states IDLE, COLLECT; o_busy = (state == COLLECT).
REQ-015 IDLE + i_frame_start -> COLLECT, byte index 0, timer 0; if i_byte_valid in same cycle, that byte is captured as byte 0 (index -> 1).
REQ-016 IDLE + i_byte_valid without i_frame_start: byte ignored, no state change.
REQ-017 COLLECT + i_byte_valid (no frame_start): byte stored at shadow[index], index+1, timer cleared.
REQ-018 Byte order little-endian: o_x = {b1,b0}, o_y = {b3,b2}, o_z = {b5,b4}; for DATA_WIDTH > 16 sign-extend from bit 15, for DATA_WIDTH < 16 keep low DATA_WIDTH bits.
REQ-019 Capture of byte 5 at edge N: o_x/o_y/o_z all load at edge N (using shadow b0..b4 plus incoming byte), o_valid high for exactly the cycle after edge N, state -> IDLE at edge N.
REQ-020 Latency from byte-5 strobe to o_valid: 1 clock; axes never update individually.
REQ-021 COLLECT + no i_byte_valid: timer increments; on reaching TIMEOUT_CYCLES-1 -> IDLE, o_err_timeout=1, o_drop_cnt+1 (saturate 255), outputs unchanged, no o_valid.
REQ-022 COLLECT + i_frame_start: partial frame discarded, o_drop_cnt+1, restart at index 0; simultaneous i_byte_valid byte captured as new byte 0.
REQ-023 Timeout and byte_valid in same cycle: byte wins, timer cleared, no abort.
REQ-024 i_err_clr clears o_err_timeout and o_drop_cnt; if an abort occurs in the same cycle, the abort wins (flag=1, count=1).
REQ-025 o_x/o_y/o_z change only at REQ-019 edges or reset.

Reset
REQ-026 i_rstn low at a clock edge: state IDLE, index 0, timer 0, shadow 0, o_x/o_y/o_z 0, o_valid 0, o_busy 0, o_err_timeout 0, o_drop_cnt 0.
REQ-027 Reset mid-frame discards partial frame without o_valid and without incrementing o_drop_cnt.

Verification
REQ-028 Frame 0x34,0x12,0xFE,0xFF,0x00,0x01 back-to-back -> o_x=0x1234, o_y=0xFFFE, o_z=0x0100, o_valid single pulse 1 clock after last byte.
REQ-029 Bytes with 3-clock gaps, then 10 idle clocks, then a second frame -> outputs hold first frame values until second o_valid; o_busy low in between.
REQ-030 TIMEOUT_CYCLES=16, 3 bytes then silence -> abort at 15th idle clock, o_err_timeout=1, o_drop_cnt=1, o_x unchanged, no o_valid.
REQ-031 i_frame_start after 4 bytes, then a full 6-byte frame -> o_drop_cnt=1, outputs reflect only new frame.
REQ-032 i_rstn low after 5 bytes, then 1 stray byte -> no o_valid, all outputs 0, stray byte ignored.
REQ-033 Drive 300 aborted frames -> o_drop_cnt saturates at 255; i_err_clr -> 0.

Source files
------------

// File: rtl/axis_sample_assembler_if.sv
// axis_sample_assembler_if
// Bundles the byte-stream input and the assembled sample output of
// axis_sample_assembler.
//   slave  : assembler side (consumes bytes, produces samples)
//   master : byte source / sample consumer side
// Signals:
//   i_frame_start, i_byte_valid, i_byte, i_err_clr : byte stream + error clear
//   o_x, o_y, o_z, o_valid                         : assembled samples
//   o_busy, o_err_timeout, o_drop_cnt              : status
interface axis_sample_assembler_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  i_frame_start;
    logic                  i_byte_valid;
    logic [7:0]            i_byte;
    logic                  i_err_clr;
    logic [DATA_WIDTH-1:0] o_x;
    logic [DATA_WIDTH-1:0] o_y;
    logic [DATA_WIDTH-1:0] o_z;
    logic                  o_valid;
    logic                  o_busy;
    logic                  o_err_timeout;
    logic [7:0]            o_drop_cnt;

    modport slave (
        input  i_frame_start, i_byte_valid, i_byte, i_err_clr,
        output o_x, o_y, o_z, o_valid, o_busy, o_err_timeout, o_drop_cnt
    );

    modport master (
        output i_frame_start, i_byte_valid, i_byte, i_err_clr,
        input  o_x, o_y, o_z, o_valid, o_busy, o_err_timeout, o_drop_cnt
    );
endinterface

// File: rtl/axis_sample_assembler.sv
// axis_sample_assembler
// Collects a 6-byte burst (X0,X1,Y0,Y1,Z0,Z1, little-endian) into three
// held axis samples, publishing all three together with a one-cycle o_valid.
// Partial frames are aborted on an inter-byte timeout or on a new
// frame_start; aborts are counted in a saturating drop counter.
// Ports:
//   clk     : rising-edge clock
//   i_rstn  : synchronous active-low reset
//   bus     : axis_sample_assembler_if.slave (byte stream in, samples/status out)
//
// state   | meaning
// --------+---------------------------------------------------
// IDLE    | waiting for i_frame_start, stray bytes ignored
// COLLECT | frame in progress, r_idx = next byte slot
module axis_sample_assembler #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int DATA_WIDTH     = 16
) (
    input  logic                          clk,
    input  logic                          i_rstn,
    axis_sample_assembler_if.slave        bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

    typedef enum logic {S_IDLE, S_COLLECT} state_t;

    state_t                r_state;
    logic [2:0]            r_idx;
    logic [TW-1:0]         r_timer;
    logic [7:0]            r_shadow [0:4];
    logic [DATA_WIDTH-1:0] r_x, r_y, r_z;
    logic                  r_valid;
    logic                  r_err;
    logic [7:0]            r_drop;

    logic [TW-1:0]         w_timer_inc;
    logic [7:0]            w_drop_abort;

    assign w_timer_inc = r_timer + TW'(1);

    // An abort in the same cycle as i_err_clr still counts: the clear
    // is overridden and the counter restarts at one.
    always_comb begin
        w_drop_abort = '0;
        if (bus.i_err_clr)
            w_drop_abort = 8'd1;
        else if (r_drop == 8'hFF)
            w_drop_abort = 8'hFF;
        else
            w_drop_abort = r_drop + 8'd1;
    end

    // Sign-extend from bit 15 or truncate to DATA_WIDTH.
    function automatic logic [DATA_WIDTH-1:0] f_ext(input logic [15:0] raw);
        return DATA_WIDTH'($signed(raw));
    endfunction

    always_ff @(posedge clk) begin
        if (!i_rstn) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_timer <= '0;
            for (int k = 0; k < 5; k++) r_shadow[k] <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_drop  <= '0;
        end else begin
            r_valid <= 1'b0;
            if (bus.i_err_clr) begin
                r_err  <= 1'b0;
                r_drop <= '0;
            end
            case (r_state)
                S_IDLE: begin
                    if (bus.i_frame_start) begin
                        r_state <= S_COLLECT;
                        r_timer <= '0;
                        if (bus.i_byte_valid) begin
                            r_shadow[0] <= bus.i_byte;
                            r_idx       <= 3'd1;
                        end else begin
                            r_idx <= 3'd0;
                        end
                    end
                end
                S_COLLECT: begin
                    if (bus.i_frame_start) begin
                        r_drop  <= w_drop_abort;
                        r_timer <= '0;
                        if (bus.i_byte_valid) begin
                            r_shadow[0] <= bus.i_byte;
                            r_idx       <= 3'd1;
                        end else begin
                            r_idx <= 3'd0;
                        end
                    end else if (bus.i_byte_valid) begin
                        // A byte always beats a coincident timeout.
                        r_timer <= '0;
                        if (r_idx == 3'd5) begin
                            r_x     <= f_ext({r_shadow[1], r_shadow[0]});
                            r_y     <= f_ext({r_shadow[3], r_shadow[2]});
                            r_z     <= f_ext({bus.i_byte, r_shadow[4]});
                            r_valid <= 1'b1;
                            r_state <= S_IDLE;
                            r_idx   <= 3'd0;
                        end else begin
                            for (int k = 0; k < 5; k++)
                                if (r_idx == 3'(k)) r_shadow[k] <= bus.i_byte;
                            r_idx <= r_idx + 3'd1;
                        end
                    end else if (w_timer_inc == TW'(TIMEOUT_CYCLES - 1)) begin
                        r_state <= S_IDLE;
                        r_idx   <= 3'd0;
                        r_timer <= '0;
                        r_err   <= 1'b1;
                        r_drop  <= w_drop_abort;
                    end else begin
                        r_timer <= w_timer_inc;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.o_x           = r_x;
    assign bus.o_y           = r_y;
    assign bus.o_z           = r_z;
    assign bus.o_valid       = r_valid;
    assign bus.o_busy        = (r_state == S_COLLECT);
    assign bus.o_err_timeout = r_err;
    assign bus.o_drop_cnt    = r_drop;
endmodule

// File: tb/tb_axis_sample_assembler.sv
// tb_axis_sample_assembler
// Directed bench for axis_sample_assembler with TIMEOUT_CYCLES=16.
// A vector table covers the basic frame path; hand-written sequences cover
// gaps, timeout, restart, mid-frame reset and drop-counter saturation.
module tb_axis_sample_assembler;
    localparam int TO = 16;
    localparam int DW = 16;

    logic clk;
    logic rstn;
    int   n_checks;
    int   n_errors;
    int   n_valid;

    axis_sample_assembler_if #(.DATA_WIDTH(DW)) bus ();

    axis_sample_assembler #(.TIMEOUT_CYCLES(TO), .DATA_WIDTH(DW)) dut (
        .clk    (clk),
        .i_rstn (rstn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        fs;
        logic        bv;
        logic [7:0]  b;
        logic        ev;
        logic        eb;
        logic [15:0] ex;
        logic [15:0] ey;
        logic [15:0] ez;
    } vec_t;

    vec_t vecs [16];

    function automatic vec_t mk(input logic fs, input logic bv, input logic [7:0] b,
                                input logic ev, input logic eb,
                                input logic [15:0] ex, input logic [15:0] ey,
                                input logic [15:0] ez);
        vec_t v;
        v.fs = fs; v.bv = bv; v.b = b; v.ev = ev; v.eb = eb;
        v.ex = ex; v.ey = ey; v.ez = ez;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic fs, input logic bv, input logic [7:0] b, input logic clr);
        @(negedge clk);
        bus.i_frame_start = fs;
        bus.i_byte_valid  = bv;
        bus.i_byte        = b;
        bus.i_err_clr     = clr;
        @(posedge clk);
        #1;
        if (bus.o_valid === 1'b1) n_valid++;
    endtask

    task automatic do_reset(input logic bv, input logic [7:0] b);
        @(negedge clk);
        rstn              = 1'b0;
        bus.i_frame_start = 1'b0;
        bus.i_byte_valid  = bv;
        bus.i_byte        = b;
        bus.i_err_clr     = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        rstn = 1'b1;
        bus.i_byte_valid = 1'b0;
    endtask

    task automatic chk_xyz(input string name, input logic [15:0] x, input logic [15:0] y,
                           input logic [15:0] z);
        chk({name, "_x"}, 32'(bus.o_x), 32'(x));
        chk({name, "_y"}, 32'(bus.o_y), 32'(y));
        chk({name, "_z"}, 32'(bus.o_z), 32'(z));
    endtask

    initial begin
        int v0;
        n_checks = 0;
        n_errors = 0;
        n_valid  = 0;
        rstn = 1'b1;
        bus.i_frame_start = 1'b0;
        bus.i_byte_valid  = 1'b0;
        bus.i_byte        = 8'h00;
        bus.i_err_clr     = 1'b0;

        do_reset(1'b0, 8'h00);
        chk("rst_busy", 32'(bus.o_busy), 0);
        chk("rst_valid", 32'(bus.o_valid), 0);
        chk("rst_err", 32'(bus.o_err_timeout), 0);
        chk("rst_drop", 32'(bus.o_drop_cnt), 0);
        chk_xyz("rst", 16'h0000, 16'h0000, 16'h0000);

        // Stray byte, REQ-028 frame, then a second frame opened without a byte.
        vecs[0]  = mk(0, 1, 8'hAA, 0, 0, 16'h0000, 16'h0000, 16'h0000);
        vecs[1]  = mk(1, 1, 8'h34, 0, 1, 16'h0000, 16'h0000, 16'h0000);
        vecs[2]  = mk(0, 1, 8'h12, 0, 1, 16'h0000, 16'h0000, 16'h0000);
        vecs[3]  = mk(0, 1, 8'hFE, 0, 1, 16'h0000, 16'h0000, 16'h0000);
        vecs[4]  = mk(0, 1, 8'hFF, 0, 1, 16'h0000, 16'h0000, 16'h0000);
        vecs[5]  = mk(0, 1, 8'h00, 0, 1, 16'h0000, 16'h0000, 16'h0000);
        vecs[6]  = mk(0, 1, 8'h01, 1, 0, 16'h1234, 16'hFFFE, 16'h0100);
        vecs[7]  = mk(0, 0, 8'h00, 0, 0, 16'h1234, 16'hFFFE, 16'h0100);
        vecs[8]  = mk(1, 0, 8'h00, 0, 1, 16'h1234, 16'hFFFE, 16'h0100);
        vecs[9]  = mk(0, 1, 8'h78, 0, 1, 16'h1234, 16'hFFFE, 16'h0100);
        vecs[10] = mk(0, 1, 8'h56, 0, 1, 16'h1234, 16'hFFFE, 16'h0100);
        vecs[11] = mk(0, 1, 8'h02, 0, 1, 16'h1234, 16'hFFFE, 16'h0100);
        vecs[12] = mk(0, 1, 8'h00, 0, 1, 16'h1234, 16'hFFFE, 16'h0100);
        vecs[13] = mk(0, 1, 8'hFF, 0, 1, 16'h1234, 16'hFFFE, 16'h0100);
        vecs[14] = mk(0, 1, 8'h7F, 1, 0, 16'h5678, 16'h0002, 16'h7FFF);
        vecs[15] = mk(0, 0, 8'h00, 0, 0, 16'h5678, 16'h0002, 16'h7FFF);

        for (int i = 0; i < 16; i++) begin
            step(vecs[i].fs, vecs[i].bv, vecs[i].b, 1'b0);
            chk($sformatf("vec%0d_valid", i), 32'(bus.o_valid), 32'(vecs[i].ev));
            chk($sformatf("vec%0d_busy", i), 32'(bus.o_busy), 32'(vecs[i].eb));
            chk_xyz($sformatf("vec%0d", i), vecs[i].ex, vecs[i].ey, vecs[i].ez);
        end
        chk("vec_drop", 32'(bus.o_drop_cnt), 0);

        // Gapped frame, idle stretch, back-to-back second frame.
        v0 = n_valid;
        step(1, 1, 8'h01, 0);
        begin
            logic [7:0] gb [5];
            gb[0] = 8'h00; gb[1] = 8'h03; gb[2] = 8'h00; gb[3] = 8'hFC; gb[4] = 8'hFF;
            for (int i = 0; i < 5; i++) begin
                for (int g = 0; g < 3; g++) step(0, 0, 8'h00, 0);
                chk($sformatf("gap%0d_busy", i), 32'(bus.o_busy), 1);
                chk($sformatf("gap%0d_x", i), 32'(bus.o_x), 32'h5678);
                step(0, 1, gb[i], 0);
            end
        end
        chk("gap_valid", 32'(bus.o_valid), 1);
        chk_xyz("gap", 16'h0001, 16'h0003, 16'hFFFC);
        for (int i = 0; i < 10; i++) step(0, 0, 8'h00, 0);
        chk("gap_idle_busy", 32'(bus.o_busy), 0);
        chk_xyz("gap_hold", 16'h0001, 16'h0003, 16'hFFFC);
        step(1, 1, 8'h10, 0);
        step(0, 1, 8'h00, 0);
        step(0, 1, 8'h20, 0);
        step(0, 1, 8'h00, 0);
        step(0, 1, 8'h30, 0);
        chk_xyz("f2_hold", 16'h0001, 16'h0003, 16'hFFFC);
        step(0, 1, 8'h00, 0);
        chk("f2_valid", 32'(bus.o_valid), 1);
        chk_xyz("f2", 16'h0010, 16'h0020, 16'h0030);
        step(0, 0, 8'h00, 0);
        chk("f2_pulse_count", 32'(n_valid - v0), 2);

        // Timeout: 3 bytes then silence, abort on the 15th idle clock.
        v0 = n_valid;
        step(1, 1, 8'hAA, 0);
        step(0, 1, 8'hBB, 0);
        step(0, 1, 8'hCC, 0);
        for (int i = 0; i < 14; i++) step(0, 0, 8'h00, 0);
        chk("to14_busy", 32'(bus.o_busy), 1);
        chk("to14_err", 32'(bus.o_err_timeout), 0);
        step(0, 0, 8'h00, 0);
        chk("to15_busy", 32'(bus.o_busy), 0);
        chk("to15_err", 32'(bus.o_err_timeout), 1);
        chk("to15_drop", 32'(bus.o_drop_cnt), 1);
        chk("to15_x", 32'(bus.o_x), 32'h0010);
        step(0, 0, 8'h00, 0);
        chk("to_no_valid", 32'(n_valid - v0), 0);
        step(0, 0, 8'h00, 1);
        chk("clr_err", 32'(bus.o_err_timeout), 0);
        chk("clr_drop", 32'(bus.o_drop_cnt), 0);

        // Byte arriving on the would-be timeout clock wins.
        step(1, 1, 8'h01, 0);
        for (int i = 0; i < 14; i++) step(0, 0, 8'h00, 0);
        step(0, 1, 8'h02, 0);
        chk("race_busy", 32'(bus.o_busy), 1);
        chk("race_err", 32'(bus.o_err_timeout), 0);
        for (int i = 0; i < 14; i++) step(0, 0, 8'h00, 0);
        chk("race2_busy", 32'(bus.o_busy), 1);
        step(0, 0, 8'h00, 0);
        chk("race2_err", 32'(bus.o_err_timeout), 1);
        chk("race2_drop", 32'(bus.o_drop_cnt), 1);
        step(0, 0, 8'h00, 1);

        // Restart after 4 bytes; new frame's byte 0 rides on frame_start.
        v0 = n_valid;
        step(1, 1, 8'h11, 0);
        step(0, 1, 8'h22, 0);
        step(0, 1, 8'h33, 0);
        step(0, 1, 8'h44, 0);
        step(1, 1, 8'hEF, 0);
        chk("rs_drop", 32'(bus.o_drop_cnt), 1);
        chk("rs_busy", 32'(bus.o_busy), 1);
        chk("rs_err", 32'(bus.o_err_timeout), 0);
        step(0, 1, 8'hBE, 0);
        step(0, 1, 8'hAD, 0);
        step(0, 1, 8'hDE, 0);
        step(0, 1, 8'h0D, 0);
        step(0, 1, 8'hF0, 0);
        chk("rs_valid", 32'(bus.o_valid), 1);
        chk_xyz("rs", 16'hBEEF, 16'hDEAD, 16'hF00D);
        chk("rs_pulse_count", 32'(n_valid - v0), 1);

        // Reset after 5 bytes, then a stray byte.
        v0 = n_valid;
        step(1, 1, 8'h01, 0);
        step(0, 1, 8'h02, 0);
        step(0, 1, 8'h03, 0);
        step(0, 1, 8'h04, 0);
        step(0, 1, 8'h05, 0);
        do_reset(1'b1, 8'h06);
        step(0, 1, 8'h06, 0);
        step(0, 0, 8'h00, 0);
        chk("mr_valid_count", 32'(n_valid - v0), 0);
        chk("mr_busy", 32'(bus.o_busy), 0);
        chk("mr_drop", 32'(bus.o_drop_cnt), 0);
        chk("mr_err", 32'(bus.o_err_timeout), 0);
        chk_xyz("mr", 16'h0000, 16'h0000, 16'h0000);

        // 300 restarts saturate the drop counter.
        step(1, 0, 8'h00, 0);
        for (int i = 0; i < 300; i++) begin
            step(1, 0, 8'h00, 0);
            if (i == 9) chk("sat_10", 32'(bus.o_drop_cnt), 10);
        end
        chk("sat_255", 32'(bus.o_drop_cnt), 255);
        step(1, 0, 8'h00, 1);
        chk("clr_restart_drop", 32'(bus.o_drop_cnt), 1);
        step(1, 0, 8'h00, 0);
        chk("drop2", 32'(bus.o_drop_cnt), 2);
        for (int i = 0; i < 14; i++) step(0, 0, 8'h00, 0);
        step(0, 0, 8'h00, 1);
        chk("clr_to_err", 32'(bus.o_err_timeout), 1);
        chk("clr_to_drop", 32'(bus.o_drop_cnt), 1);
        step(0, 0, 8'h00, 1);
        chk("final_err", 32'(bus.o_err_timeout), 0);
        chk("final_drop", 32'(bus.o_drop_cnt), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
